// File: rtl/cnt_rr_sched_if.sv
// Requester and counter signal bundle for cnt_rr_sched.
// master: requesters plus the external counter; slave: the scheduler.
interface cnt_rr_sched_if;
    localparam int unsigned CntW = 5;
    localparam int unsigned OpW  = 2;

    // Requester side
    logic            req_a;
    logic            req_b;
    logic [OpW-1:0]  op_a;
    logic [OpW-1:0]  op_b;
    logic            gnt_a;
    logic            gnt_b;
    logic            done_a;
    logic            done_b;
    logic            err;
    logic [CntW-1:0] rd_val;
    logic            busy;

    // Counter side
    logic            cnt_u;
    logic            cnt_d;
    logic            cnt_clr;
    logic [CntW-1:0] cnt_val;
    logic            cnt_zero;

    modport master (
        output req_a, req_b, op_a, op_b, cnt_val, cnt_zero,
        input  gnt_a, gnt_b, done_a, done_b, err, rd_val, busy,
               cnt_u, cnt_d, cnt_clr
    );

    modport slave (
        input  req_a, req_b, op_a, op_b, cnt_val, cnt_zero,
        output gnt_a, gnt_b, done_a, done_b, err, rd_val, busy,
               cnt_u, cnt_d, cnt_clr
    );
endinterface

// File: rtl/cnt_rr_sched.sv
// Round-robin scheduler granting two requesters exclusive access to a shared
// 5-bit up/down counter. Each transaction runs IDLE -> ISSUE -> DONE.
// Optional macro COUNTER_SAT_EN: refuse up at 31 / down at 0 and flag err
// instead of letting the counter wrap.
module cnt_rr_sched (
    input  logic                 clk,
    input  logic                 rst,
    cnt_rr_sched_if.slave        bus
);
    localparam int unsigned CntW = 5;
    localparam int unsigned OpW  = 2;

    localparam logic [OpW-1:0]  OP_NOP = 2'b00;
    localparam logic [OpW-1:0]  OP_UP  = 2'b01;
    localparam logic [OpW-1:0]  OP_DN  = 2'b10;
    localparam logic [OpW-1:0]  OP_CLR = 2'b11;
    localparam logic [CntW-1:0] CNT_MAX = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e          state_q;
    logic            rr_q;        // 0: A has priority, 1: B has priority
    logic            win_q;       // 0: A owns the transaction, 1: B
    logic            refuse_q;    // latched saturation refusal
    logic            gnt_a_q;
    logic            gnt_b_q;
    logic            done_a_q;
    logic            done_b_q;
    logic            err_q;
    logic            busy_q;
    logic            cnt_u_q;
    logic            cnt_d_q;
    logic            cnt_clr_q;
    logic [CntW-1:0] rd_hold_q;

    logic            grant_c;
    logic            win_c;
    logic [OpW-1:0]  op_c;
    logic            refuse_c;

    // Arbitration: lone request wins, simultaneous requests go to rr_q.
    always_comb begin
        grant_c = 1'b0;
        win_c   = rr_q;
        if (bus.req_a && bus.req_b) begin
            grant_c = 1'b1;
            win_c   = rr_q;
        end else if (bus.req_a) begin
            grant_c = 1'b1;
            win_c   = 1'b0;
        end else if (bus.req_b) begin
            grant_c = 1'b1;
            win_c   = 1'b1;
        end
        op_c = win_c ? bus.op_b : bus.op_a;
    end

`ifdef COUNTER_SAT_EN
    // Refuse operations that would wrap the counter.
    always_comb begin
        refuse_c = 1'b0;
        if ((op_c == OP_UP) && (bus.cnt_val == CNT_MAX)) begin
            refuse_c = 1'b1;
        end else if ((op_c == OP_DN) && bus.cnt_zero) begin
            refuse_c = 1'b1;
        end
    end
`else
    // Wrapping counter: every up/down is issued.
    logic unused_cnt_zero;
    assign refuse_c        = 1'b0;
    assign unused_cnt_zero = bus.cnt_zero;
`endif

    // Transaction FSM with registered grant, command and completion outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rr_q      <= 1'b0;
            win_q     <= 1'b0;
            refuse_q  <= 1'b0;
            gnt_a_q   <= 1'b0;
            gnt_b_q   <= 1'b0;
            done_a_q  <= 1'b0;
            done_b_q  <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            cnt_u_q   <= 1'b0;
            cnt_d_q   <= 1'b0;
            cnt_clr_q <= 1'b0;
            rd_hold_q <= '0;
        end else begin
            // Single-cycle pulses default low.
            gnt_a_q   <= 1'b0;
            gnt_b_q   <= 1'b0;
            done_a_q  <= 1'b0;
            done_b_q  <= 1'b0;
            err_q     <= 1'b0;
            cnt_u_q   <= 1'b0;
            cnt_d_q   <= 1'b0;
            cnt_clr_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    busy_q <= 1'b0;
                    if (grant_c) begin
                        state_q   <= ST_ISSUE;
                        busy_q    <= 1'b1;
                        win_q     <= win_c;
                        refuse_q  <= refuse_c;
                        rr_q      <= ~win_c;
                        gnt_a_q   <= ~win_c;
                        gnt_b_q   <= win_c;
                        cnt_u_q   <= (op_c == OP_UP)  && !refuse_c;
                        cnt_d_q   <= (op_c == OP_DN)  && !refuse_c;
                        cnt_clr_q <= (op_c == OP_CLR);
                    end
                end
                ST_ISSUE: begin
                    state_q  <= ST_DONE;
                    busy_q   <= 1'b1;
                    done_a_q <= ~win_q;
                    done_b_q <= win_q;
                    err_q    <= refuse_q;
                end
                ST_DONE: begin
                    state_q   <= ST_IDLE;
                    busy_q    <= 1'b0;
                    rd_hold_q <= bus.cnt_val;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt_a   = gnt_a_q;
    assign bus.gnt_b   = gnt_b_q;
    assign bus.done_a  = done_a_q;
    assign bus.done_b  = done_b_q;
    assign bus.err     = err_q;
    assign bus.busy    = busy_q;
    assign bus.cnt_u   = cnt_u_q;
    assign bus.cnt_d   = cnt_d_q;
    assign bus.cnt_clr = cnt_clr_q;

    // The counter only settles at the edge ending ISSUE, so the post-update
    // value is passed through during DONE and held from then on.
    assign bus.rd_val = (state_q == ST_DONE) ? bus.cnt_val : rd_hold_q;

    // OP_NOP is implied by the absence of any command.
    logic unused_op_nop;
    assign unused_op_nop = ^OP_NOP;
endmodule

// File: tb/tb_cnt_rr_sched.sv
// Directed bench for cnt_rr_sched with a behavioural 5-bit counter.
module tb_cnt_rr_sched;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cnt_rr_sched_if bus ();
    cnt_rr_sched dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef COUNTER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    // External counter model with a bench preload port.
    logic [4:0] cnt_q;
    logic       load_en;
    logic [4:0] load_val;
    always @(posedge clk) begin
        if (load_en)          cnt_q <= load_val;
        else if (bus.cnt_clr) cnt_q <= 5'd0;
        else if (bus.cnt_u)   cnt_q <= cnt_q + 5'd1;
        else if (bus.cnt_d)   cnt_q <= cnt_q - 5'd1;
    end
    assign bus.cnt_val  = cnt_q;
    assign bus.cnt_zero = (cnt_q == 5'd0);

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    typedef struct {
        logic       ra, rb;
        logic [1:0] oa, ob;
        logic [4:0] cnt;
        logic       ga, gb, u, d, clr, err;
        logic [4:0] rd;
    } vec_t;

    vec_t vecs[10];

    task automatic run_vec(input vec_t v, input int idx);
        @(negedge clk);
        load_en = 1'b1; load_val = v.cnt;
        @(negedge clk);
        load_en = 1'b0;
        bus.req_a = v.ra; bus.req_b = v.rb; bus.op_a = v.oa; bus.op_b = v.ob;
        @(negedge clk); // ISSUE
        bus.req_a = 1'b0; bus.req_b = 1'b0; bus.op_a = ~v.oa; bus.op_b = ~v.ob;
        chk($sformatf("v%0d gnt_a", idx), 32'(bus.gnt_a), 32'(v.ga));
        chk($sformatf("v%0d gnt_b", idx), 32'(bus.gnt_b), 32'(v.gb));
        chk($sformatf("v%0d cnt_u", idx), 32'(bus.cnt_u), 32'(v.u));
        chk($sformatf("v%0d cnt_d", idx), 32'(bus.cnt_d), 32'(v.d));
        chk($sformatf("v%0d cnt_clr", idx), 32'(bus.cnt_clr), 32'(v.clr));
        chk($sformatf("v%0d busy_issue", idx), 32'(bus.busy), 32'd1);
        @(negedge clk); // DONE
        chk($sformatf("v%0d done_a", idx), 32'(bus.done_a), 32'(v.ga));
        chk($sformatf("v%0d done_b", idx), 32'(bus.done_b), 32'(v.gb));
        chk($sformatf("v%0d err", idx), 32'(bus.err), 32'(v.err));
        chk($sformatf("v%0d rd_val", idx), 32'(bus.rd_val), 32'(v.rd));
        chk($sformatf("v%0d cmd_off_done", idx),
            32'({bus.gnt_a, bus.gnt_b, bus.cnt_u, bus.cnt_d, bus.cnt_clr}), 32'd0);
        @(negedge clk); // IDLE
        chk($sformatf("v%0d done_off", idx), 32'({bus.done_a, bus.done_b, bus.err}), 32'd0);
        chk($sformatf("v%0d rd_hold", idx), 32'(bus.rd_val), 32'(v.rd));
        chk($sformatf("v%0d busy_idle", idx), 32'(bus.busy), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; load_en = 1'b1; load_val = 5'd0;
        bus.req_a = 1'b0; bus.req_b = 1'b0; bus.op_a = 2'b00; bus.op_b = 2'b00;
        repeat (2) @(negedge clk);
        rst = 1'b0; load_en = 1'b0;
    endtask

    initial begin
        // ra rb oa ob cnt | ga gb u d clr err rd
        vecs[0] = '{1, 0, 2'b01, 2'b00, 5'd0,  1, 0, 1, 0, 0, 0, 5'd1};
        vecs[1] = '{0, 1, 2'b00, 2'b10, 5'd5,  0, 1, 0, 1, 0, 0, 5'd4};
        vecs[2] = '{1, 0, 2'b11, 2'b00, 5'd12, 1, 0, 0, 0, 1, 0, 5'd0};
        vecs[3] = '{0, 1, 2'b01, 2'b00, 5'd7,  0, 1, 0, 0, 0, 0, 5'd7};
        if (SAT) begin
            vecs[4] = '{1, 0, 2'b01, 2'b00, 5'd31, 1, 0, 0, 0, 0, 1, 5'd31};
            vecs[5] = '{0, 1, 2'b00, 2'b10, 5'd0,  0, 1, 0, 0, 0, 1, 5'd0};
        end else begin
            vecs[4] = '{1, 0, 2'b01, 2'b00, 5'd31, 1, 0, 1, 0, 0, 0, 5'd0};
            vecs[5] = '{0, 1, 2'b00, 2'b10, 5'd0,  0, 1, 0, 1, 0, 0, 5'd31};
        end
        vecs[6] = '{1, 1, 2'b01, 2'b10, 5'd3,  1, 0, 1, 0, 0, 0, 5'd4};
        vecs[7] = '{1, 1, 2'b11, 2'b01, 5'd9,  0, 1, 1, 0, 0, 0, 5'd10};
        vecs[8] = '{0, 1, 2'b00, 2'b01, 5'd30, 0, 1, 1, 0, 0, 0, 5'd31};
        vecs[9] = '{1, 1, 2'b10, 2'b11, 5'd20, 1, 0, 0, 1, 0, 0, 5'd19};

        rst = 1'b1;
        do_reset();
        chk("reset outputs",
            32'({bus.gnt_a, bus.gnt_b, bus.done_a, bus.done_b, bus.err, bus.busy,
                 bus.cnt_u, bus.cnt_d, bus.cnt_clr}), 32'd0);
        chk("reset rd_val", 32'(bus.rd_val), 32'd0);

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // Reset while a transaction is in ISSUE aborts it.
        @(negedge clk);
        load_en = 1'b1; load_val = 5'd5;
        @(negedge clk);
        load_en = 1'b0; bus.req_a = 1'b1; bus.op_a = 2'b01;
        @(negedge clk);
        bus.req_a = 1'b0;
        chk("abort pre gnt_a", 32'(bus.gnt_a), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort outputs",
            32'({bus.gnt_a, bus.gnt_b, bus.done_a, bus.done_b, bus.err, bus.busy,
                 bus.cnt_u, bus.cnt_d, bus.cnt_clr}), 32'd0);
        chk("abort rd_val", 32'(bus.rd_val), 32'd0);
        @(negedge clk);
        chk("abort no done", 32'({bus.done_a, bus.done_b, bus.busy}), 32'd0);

        // Simultaneous requests: A first, B on next IDLE, then alternation.
        load_en = 1'b1; load_val = 5'd0;
        @(negedge clk);
        load_en = 1'b0;
        bus.req_a = 1'b1; bus.req_b = 1'b1; bus.op_a = 2'b01; bus.op_b = 2'b01;
        @(negedge clk);
        bus.req_a = 1'b0;
        chk("rr1 gnt", 32'({bus.gnt_a, bus.gnt_b, bus.cnt_u}), 32'b101);
        @(negedge clk);
        chk("rr1 done_a", 32'({bus.done_a, bus.done_b}), 32'b10);
        chk("rr1 rd_val", 32'(bus.rd_val), 32'd1);
        @(negedge clk);
        chk("rr1 idle busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        bus.req_b = 1'b0;
        chk("rr2 gnt", 32'({bus.gnt_a, bus.gnt_b, bus.cnt_u}), 32'b011);
        @(negedge clk);
        chk("rr2 done_b", 32'({bus.done_a, bus.done_b}), 32'b01);
        chk("rr2 rd_val", 32'(bus.rd_val), 32'd2);
        @(negedge clk);
        bus.req_a = 1'b1; bus.req_b = 1'b1; bus.op_a = 2'b10; bus.op_b = 2'b10;
        @(negedge clk);
        bus.req_a = 1'b0; bus.req_b = 1'b0;
        chk("rr3 gnt", 32'({bus.gnt_a, bus.gnt_b, bus.cnt_d}), 32'b101);
        @(negedge clk);
        chk("rr3 rd_val", 32'(bus.rd_val), 32'd1);
        @(negedge clk);
        bus.req_a = 1'b1; bus.req_b = 1'b1; bus.op_a = 2'b01; bus.op_b = 2'b11;
        @(negedge clk);
        bus.req_a = 1'b0; bus.req_b = 1'b0;
        chk("rr4 gnt", 32'({bus.gnt_a, bus.gnt_b, bus.cnt_clr, bus.cnt_u}), 32'b0110);
        @(negedge clk);
        chk("rr4 done_b", 32'({bus.done_a, bus.done_b}), 32'b01);
        chk("rr4 rd_val", 32'(bus.rd_val), 32'd0);

        // Request arriving during ISSUE/DONE is dropped, not queued.
        @(negedge clk);
        bus.req_a = 1'b1; bus.op_a = 2'b00;
        @(negedge clk);
        bus.req_a = 1'b0; bus.req_b = 1'b1; bus.op_b = 2'b01;
        chk("nop gnt_a", 32'({bus.gnt_a, bus.cnt_u, bus.cnt_d, bus.cnt_clr}), 32'b1000);
        @(negedge clk);
        bus.req_b = 1'b0;
        chk("nop done_a", 32'({bus.done_a, bus.done_b}), 32'b10);
        @(negedge clk);
        @(negedge clk);
        chk("ignored req", 32'({bus.gnt_b, bus.busy}), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/cnt_rr_sched.md
CNT_RR_SCHED -- requirements
Module: cnt_rr_sched

Interface
REQ-001 SHALL have port clk  input  1  clock; all logic rising-edge triggered.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have ports req_a / req_b  input  1 each  transaction request from requester A / B.
REQ-004 SHALL have ports op_a / op_b  input  2 each  operation: 00 nop, 01 up, 10 down, 11 clear.
REQ-005 SHALL have ports gnt_a / gnt_b  output  1 each  requester owns counter this cycle.
REQ-006 SHALL have ports done_a / done_b  output  1 each  one-cycle completion pulse.
REQ-007 SHALL have port err  output  1  refused operation, valid with done_x.
REQ-008 SHALL have port rd_val  output  5  counter value after the operation, valid with done_x.
REQ-009 SHALL have ports cnt_u / cnt_d / cnt_clr  output  1 each  drive counter cntU / cntD / rst5.
REQ-010 SHALL have ports cnt_val  input  5  counter result; cnt_zero  input  1  counter down_done.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-012 SHALL implement FSM IDLE -> ISSUE -> DONE -> IDLE, one cycle per state.
REQ-013 SHALL sample req_a/req_b only in IDLE; requests in ISSUE/DONE are ignored, not queued.
REQ-014 SHALL arbitrate round-robin: single request wins; on simultaneous requests, winner = rr_ptr; rr_ptr moves to loser after every grant.
REQ-015 SHALL latch winner id and op on IDLE->ISSUE; the op is not re-sampled afterwards.
REQ-016 SHALL assert gnt_x and exactly one of cnt_u/cnt_d/cnt_clr for op 01/10/11 during ISSUE only; op 00 asserts none.
REQ-017 SHALL, in DONE, pulse done_x for the winner for one cycle, with rd_val = cnt_val sampled in DONE (post-update value).
REQ-018 SHALL give latency req-in-IDLE (cycle 0) -> command (cycle 1) -> done (cycle 2); max throughput 1 op per 3 cycles.
REQ-019 SHALL treat req_x still high in the IDLE cycle following DONE as a new transaction; requesters drop req_x on the edge ending done_x.
REQ-020 SHALL keep gnt_a and gnt_b mutually exclusive, and cnt_u, cnt_d, cnt_clr mutually exclusive.
REQ-021 SHALL hold rd_val between done pulses; err is 0 outside done cycles.

Reset
REQ-022 SHALL, on rst, force IDLE, rr_ptr = A, and all outputs to 0, including rd_val = 5'd0.
REQ-023 SHALL abort an in-flight transaction on rst: no done pulse, no counter command after the reset cycle.
REQ-024 SHALL not drive the counter's own reset; counter reset is a system-level connection.

Configuration
REQ-025 SHALL honour macro COUNTER_SAT_EN.
REQ-026 With COUNTER_SAT_EN defined: op 01 with cnt_val==31 or op 10 with cnt_zero==1 SHALL issue no command and complete normally with err=1, rd_val unchanged.
REQ-027 Without COUNTER_SAT_EN: up/down SHALL always be issued (31+1 wraps to 0, 0-1 wraps to 31) and err is tied to 0.

Verification
REQ-028 Reset, then req_a=1 op_a=01 at cnt 0 -> cnt_u high cycle 1, done_a cycle 2, rd_val=1, err=0.
REQ-029 req_a and req_b both high, op 01, in IDLE after reset -> A served first (rd_val=1), then B on its next IDLE sample (rd_val=2); rr_ptr alternates on repeats.
REQ-030 cnt=31, op 01: SAT on -> no cnt_u, err=1, rd_val=31; SAT off -> cnt_u, rd_val=0, err=0.
REQ-031 cnt=0, op 10: SAT on -> no cnt_d, err=1; SAT off -> rd_val=31; cnt=12, op 11 -> cnt_clr pulse, rd_val=0.
REQ-032 rst asserted during ISSUE -> next cycle IDLE, no done_x, gnt/cnt_* low, rd_val=0.
